// File: rtl/tx_multi_ch_arbiter_pkg.sv
// Shared constants, FSM states and helpers for tx_multi_ch_arbiter.
// No ports: imported by ch_fifo and tx_multi_ch_arbiter.
package tx_multi_ch_arbiter_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'h817E;
  localparam logic [15:0] IDLE_WORD_DEF = 16'h1E00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_RUN
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ch_fifo.sv
// ch_fifo: single-clock FIFO, one per input channel.
// Ports: clk, rst (async low), push/wdata, pop/rdata, full, empty, count.
module ch_fifo
  import tx_multi_ch_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  output logic [DATA_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_multi_ch_arbiter.sv
// tx_multi_ch_arbiter: per-channel FIFOs merged round-robin onto one
// GTX TX word stream with link-up alignment, periodic sync and idle fill.
// Ports: clk, rst (async low); in_data/in_valid/in_ready per channel;
// tx_ready link status; out_data/out_valid/out_sync/out_ch registered
// TX word; ovf_flag sticky overflow; fifo_empty per-channel status.
module tx_multi_ch_arbiter
  import tx_multi_ch_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int SYNC_PERIOD = 32,
  parameter int ALIGN_LEN = 4,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEF),
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(IDLE_WORD_DEF),
  localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     tx_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sync,
  output logic [CH_W-1:0]          out_ch,
  output logic [NUM_CH-1:0]        ovf_flag,
  output logic [NUM_CH-1:0]        fifo_empty
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int SW = clog2(SYNC_PERIOD);
  localparam int AW = clog2(ALIGN_LEN) + 1;
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PERIOD - 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_LEN - 1);

  logic [DATA_W-1:0] rd_data [NUM_CH];
  logic [CW-1:0] fill [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] avail;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  state_t state, state_d;
  logic [CH_W-1:0] grant, grant_d, sel;
  logic found;
  logic sync_due;
  logic take;
  logic [SW-1:0] sync_cnt, sync_d;
  logic [AW-1:0] align_cnt, align_d;
  logic [DATA_W-1:0] data_d;
  logic valid_d;
  logic sync_o_d;
  logic [CH_W-1:0] ch_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = in_valid[c] && !full[c];
    assign avail[c] = (fill[c] != '0);
    ch_fifo #(
      .DATA_W(DATA_W),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push[c]),
      .wdata(in_data[c*DATA_W +: DATA_W]),
      .pop(pop[c]),
      .rdata(rd_data[c]),
      .full(full[c]),
      .empty(fifo_empty[c]),
      .count(fill[c])
    );
  end

  assign in_ready = ~full;

  // First non-empty channel after the last grant, wrapping.
  always_comb begin
    logic [CH_W-1:0] cand;
    found = 1'b0;
    sel = '0;
    cand = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(grant) + i) % NUM_CH);
      if (!found && avail[cand]) begin
        found = 1'b1;
        sel = cand;
      end
    end
  end

  assign sync_due = (sync_cnt == SYNC_LAST);
  assign take = found && !sync_due;

  always_comb begin
    state_d = state;
    grant_d = grant;
    sync_d = sync_cnt;
    align_d = align_cnt;
    data_d = IDLE_WORD;
    valid_d = 1'b0;
    sync_o_d = 1'b0;
    ch_d = '0;
    pop = '0;
    if (!tx_ready) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_d = ST_ALIGN;
          align_d = '0;
        end
        ST_ALIGN: begin
          data_d = SYNC_WORD;
          sync_o_d = 1'b1;
          align_d = align_cnt + 1'b1;
          if (align_cnt == ALIGN_LAST) begin
            state_d = ST_RUN;
            sync_d = '0;
          end
        end
        ST_RUN: begin
          unique case (1'b1)
            sync_due: begin
              data_d = SYNC_WORD;
              sync_o_d = 1'b1;
              sync_d = '0;
            end
            take: begin
              pop[sel] = 1'b1;
              data_d = rd_data[sel];
              valid_d = 1'b1;
              ch_d = sel;
              grant_d = sel;
              sync_d = sync_cnt + 1'b1;
            end
            default: sync_d = sync_cnt + 1'b1;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      grant <= CH_W'(NUM_CH - 1);
      sync_cnt <= '0;
      align_cnt <= '0;
      out_data <= IDLE_WORD;
      out_valid <= 1'b0;
      out_sync <= 1'b0;
      out_ch <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      sync_cnt <= sync_d;
      align_cnt <= align_d;
      out_data <= data_d;
      out_valid <= valid_d;
      out_sync <= sync_o_d;
      out_ch <= ch_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_flag <= '0;
    else ovf_flag <= ovf_flag | (in_valid & full);
  end

endmodule

// File: tb/tb_tx_multi_ch_arbiter.sv
// Bench for tx_multi_ch_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_tx_multi_ch_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int SP = 32;
  localparam int AL = 4;
  localparam logic [15:0] SYNC = 16'h817E;
  localparam logic [15:0] IDLE = 16'h1E00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH*DW-1:0] in_data = '0;
  logic [NUM_CH-1:0] in_valid = '0;
  logic [NUM_CH-1:0] in_ready;
  logic tx_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic out_sync;
  logic [1:0] out_ch;
  logic [NUM_CH-1:0] ovf_flag;
  logic [NUM_CH-1:0] fifo_empty;

  tx_multi_ch_arbiter #(
    .NUM_CH(NUM_CH),
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .SYNC_PERIOD(SP),
    .ALIGN_LEN(AL),
    .SYNC_WORD(SYNC),
    .IDLE_WORD(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx_ready(tx_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_sync(out_sync),
    .out_ch(out_ch),
    .ovf_flag(ovf_flag),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel queues; link phase derived from how
  // many consecutive cycles tx_ready has been sampled high.
  logic [15:0] mq [NUM_CH][$];
  int up;
  int last;
  logic [NUM_CH-1:0] m_ovf;
  logic [15:0] e_data;
  logic e_valid;
  logic e_sync;
  int e_ch;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    up = 0;
    last = NUM_CH - 1;
    m_ovf = '0;
    e_data = IDLE;
    e_valid = 1'b0;
    e_sync = 1'b0;
    e_ch = 0;
  endfunction

  function automatic int qtotal();
    int t;
    t = 0;
    for (int c = 0; c < NUM_CH; c++) t += mq[c].size();
    return t;
  endfunction

  function automatic void model_edge();
    logic [NUM_CH-1:0] full_pre;
    int r;
    bit got;
    for (int c = 0; c < NUM_CH; c++)
      full_pre[c] = (mq[c].size() >= DEPTH);
    e_data = IDLE;
    e_valid = 1'b0;
    e_sync = 1'b0;
    if (!tx_ready) begin
      up = 0;
    end else begin
      if (up >= 1 && up <= AL) begin
        e_data = SYNC;
        e_sync = 1'b1;
      end else if (up > AL) begin
        r = up - AL - 1;
        if (r % SP == SP - 1) begin
          e_data = SYNC;
          e_sync = 1'b1;
        end else begin
          got = 1'b0;
          for (int i = 1; i <= NUM_CH; i++) begin
            int c;
            c = (last + i) % NUM_CH;
            if (!got && mq[c].size() > 0) begin
              got = 1'b1;
              e_data = mq[c].pop_front();
              e_valid = 1'b1;
              e_ch = c;
              last = c;
            end
          end
        end
      end
      up++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_valid[c]) begin
        if (full_pre[c]) m_ovf[c] = 1'b1;
        else mq[c].push_back(in_data[c*DW +: DW]);
      end
    end
  endfunction

  task automatic check_model();
    logic [NUM_CH-1:0] rdy;
    logic [NUM_CH-1:0] emp;
    for (int c = 0; c < NUM_CH; c++) begin
      rdy[c] = (mq[c].size() < DEPTH);
      emp[c] = (mq[c].size() == 0);
    end
    chk("out_data", out_data, e_data);
    chk("out_valid", out_valid, e_valid);
    chk("out_sync", out_sync, e_sync);
    if (e_valid) chk("out_ch", out_ch, e_ch);
    chk("in_ready", in_ready, rdy);
    chk("fifo_empty", fifo_empty, emp);
    chk("ovf_flag", ovf_flag, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Pulls rst low between edges and checks the outputs react at once.
  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    chk("rst_data", out_data, IDLE);
    chk("rst_valid", out_valid, 0);
    chk("rst_sync", out_sync, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_empty", fifo_empty, 4'hF);
    chk("rst_ovf", ovf_flag, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_data", out_data, IDLE);
    rst = 1'b1;
  endtask

  typedef struct {
    logic tx;
    logic [3:0] v;
    logic [7:0] b;
    logic [15:0] data;
    logic valid;
    logic sync;
    logic [1:0] ch;
    logic [3:0] rdy;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int pay;
    int nsync;
    int lastsync;
    int hold;

    for (int k = 0; k < 20; k++)
      tbl[k] = '{1'b1, 4'h0, 8'h00, IDLE, 1'b0, 1'b0, 2'd0, 4'hF};
    for (int k = 1; k <= AL; k++) begin
      tbl[k].data = SYNC;
      tbl[k].sync = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      tbl[5+k].v = 4'hF;
      tbl[5+k].b = 8'(k + 1);
    end
    for (int k = 0; k < 12; k++) begin
      tbl[6+k].data = {4'hA, 4'(k % 4), 8'(k / 4 + 1)};
      tbl[6+k].valid = 1'b1;
      tbl[6+k].ch = 2'(k % 4);
    end

    tx_ready = 1'b1;
    async_reset();

    for (int k = 0; k < 20; k++) begin
      tx_ready = tbl[k].tx;
      in_valid = tbl[k].v;
      for (int c = 0; c < NUM_CH; c++)
        in_data[c*DW +: DW] = {4'hA, 4'(c), tbl[k].b};
      step();
      chk("tbl_data", out_data, tbl[k].data);
      chk("tbl_valid", out_valid, tbl[k].valid);
      chk("tbl_sync", out_sync, tbl[k].sync);
      if (tbl[k].valid) chk("tbl_ch", out_ch, tbl[k].ch);
      chk("tbl_in_ready", in_ready, tbl[k].rdy);
    end

    // Overflow while the link is down.
    async_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 4'b0010;
      in_data = '0;
      in_data[DW +: DW] = 16'hB100 + 16'(i);
      step();
    end
    in_valid = '0;
    chk("ovf_in_ready1", in_ready[1], 0);
    chk("ovf_flag", ovf_flag, 4'b0010);
    tx_ready = 1'b1;
    step();
    chk("ovf_idle", out_data, IDLE);
    for (int i = 0; i < AL; i++) begin
      step();
      chk("ovf_align", out_sync, 1);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ovf_word", out_data, 16'hB100 + 16'(i));
      chk("ovf_word_ch", out_ch, 1);
      chk("ovf_word_valid", out_valid, 1);
    end
    step();
    chk("ovf_drain_done", out_valid, 0);

    // Sustained traffic: sync spacing.
    async_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 1 + AL; i++) step();
    nsync = 0;
    lastsync = -1;
    for (int n = 0; n < 100; n++) begin
      in_valid = in_ready;
      in_data = {$urandom, $urandom};
      step();
      if (out_sync) begin
        chk("sync_gap", n - lastsync, SP);
        chk("sync_no_pop", out_valid, 0);
        lastsync = n;
        nsync++;
      end
    end
    in_valid = '0;
    chk("sync_count", nsync, 3);

    // Link drop with words queued.
    async_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 1 + AL; i++) step();
    pay = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 4'hF;
      in_data = {$urandom, $urandom};
      step();
      if (out_valid) pay++;
    end
    in_valid = '0;
    for (int n = 0; n < 10 && qtotal() != 5; n++) begin
      step();
      if (out_valid) pay++;
    end
    chk("drop_queued", qtotal(), 5);
    tx_ready = 1'b0;
    step();
    chk("drop_idle", out_data, IDLE);
    chk("drop_valid", out_valid, 0);
    step();
    step();
    tx_ready = 1'b1;
    step();
    chk("relink_idle", out_data, IDLE);
    for (int i = 0; i < AL; i++) begin
      step();
      chk("relink_align", out_data, SYNC);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) pay++;
    end
    chk("drop_payload_total", pay, 8);

    // Random traffic against the model.
    async_reset();
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 39) == 0) hold = $urandom_range(1, 4);
      tx_ready = (hold == 0);
      in_valid = 4'($urandom) & 4'($urandom);
      in_data = {$urandom, $urandom};
      step();
    end

    // Reset in the middle of a run.
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 4'hF;
      in_data = {$urandom, $urandom};
      step();
    end
    in_valid = '0;
    async_reset();
    for (int i = 0; i < 8; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_multi_ch_arbiter.md
Name: tx_multi_ch_arbiter

Overview:
Parametrised successor to the single-channel TTC-to-GTX FIFO controller. It accepts NUM_CH independent DATA_W-bit word streams and buffers each one in its own FIFO. Buffered words are merged round-robin into a single DATA_W-bit stream for the GTX TX data path. The block inserts an alignment burst when the link comes up, periodic sync words, and idle fill, and reports per-channel occupancy and overflow.

Parameters:
NUM_CH, 4, number of input channels (1..16)
DATA_W, 16, word width; matches GTX txdata width
DEPTH, 8, per-channel FIFO depth in words; power of 2, at least 2
SYNC_PERIOD, 32, output words between periodic sync words (at least 4)
ALIGN_LEN, 4, consecutive sync words sent on link-up
SYNC_WORD, 16'h817E, sync/alignment word
IDLE_WORD, 16'h1E00, fill word when no data is available

Ports:
clk  in  1  single clock; all logic is in this domain (the 160 MHz fabric clock)
rst  in  1  asynchronous, active-low reset
in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
in_valid  in  NUM_CH  per-channel write request
in_ready  out  NUM_CH  per-channel FIFO not full
tx_ready  in  1  GTX TX reset done and user clock locked
out_data  out  DATA_W  registered word to GTX
out_valid  out  1  out_data carries channel payload
out_sync  out  1  out_data is SYNC_WORD
out_ch  out  CH_W  source channel of payload; CH_W = max(1, clog2(NUM_CH))
ovf_flag  out  NUM_CH  sticky: in_valid was asserted while in_ready was low
fifo_empty  out  NUM_CH  per-channel empty status

Behaviour:
- Reset (rst low, asynchronous):
  - FIFOs empty; in_ready all 1; fifo_empty all 1
  - out_data = IDLE_WORD; out_valid = 0; out_sync = 0; out_ch = 0
  - ovf_flag = 0; FSM in IDLE; grant pointer = NUM_CH-1; sync and align counters = 0
- Write side:
  - in_ready[c] = !full[c], computed from the current registered state. There is no bypass, so a full FIFO refuses a write even when it is popped in the same cycle.
  - A push happens when in_valid[c] and in_ready[c] are both high.
  - A write while full drops the word and sets ovf_flag[c]. The flag clears only on reset.
  - Simultaneous push and pop on a FIFO that is neither empty nor full leaves its count unchanged.
  - Pointers wrap modulo DEPTH. The count is clog2(DEPTH)+1 bits wide.
  - FIFOs accept writes in every FSM state.
- FSM:
  - IDLE:
    - Outputs IDLE_WORD with out_valid = 0 and out_sync = 0; no pops.
    - tx_ready = 1 -> ALIGN, align counter = 0.
  - ALIGN:
    - Outputs SYNC_WORD with out_sync = 1 each cycle.
    - After ALIGN_LEN words -> RUN, sync counter = 0.
  - RUN: each cycle, in priority order:
    - (a) If sync counter = SYNC_PERIOD-1: emit SYNC_WORD with out_sync = 1, sync counter -> 0, no pop.
    - (b) Else if any FIFO is non-empty: grant the first non-empty channel searching from grant+1 with wrap. Pop one word, out_data = that word, out_valid = 1, out_ch = channel index, grant pointer = that channel.
    - (c) Else: emit IDLE_WORD with out_valid = 0.
    - In cases (b) and (c) the sync counter increments.
  - tx_ready = 0 in any state -> IDLE on the next edge. The cycle in which tx_ready is sampled low performs no pop. FIFO contents are preserved, and the next link-up repeats ALIGN.
- Latency: a word pushed at edge t is eligible for pop at t+1 and appears on out_data after edge t+1 at the earliest, i.e. two cycles from in_valid to out_data.
- Fairness: each non-empty channel is granted at least once every NUM_CH payload slots.
- Outputs are registered and have no combinational path from the inputs, except in_ready, which is registered state.

Decomposition:
- Shared package: SYNC_WORD and IDLE_WORD defaults, the FSM state encoding (IDLE, ALIGN, RUN), and a clog2 function.
- One sub-module, ch_fifo: a single-clock synchronous FIFO with DATA_W and DEPTH parameters, full/empty/count outputs and async active-low rst. It is instantiated NUM_CH times with generate.
- The arbiter and FSM stay in the top.

Test Plan:
- Reset with tx_ready = 1 -> out_data = 16'h1E00, out_valid = 0, in_ready = 4'hF. After release: 4 cycles of 16'h817E with out_sync = 1, then IDLE_WORD.
- Push 3 words into each of ch0..ch3 in the same cycle, in RUN -> payload order ch0, ch1, ch2, ch3, ch0, ... with out_ch matching and per-channel word order preserved. First payload appears 2 cycles after the push.
- Keep all FIFOs non-empty for 100 cycles -> SYNC_WORD exactly every 32nd output word, and no pop on sync cycles.
- Push 9 words into ch1 while tx_ready = 0 -> first 8 accepted, in_ready[1] = 0, ovf_flag[1] = 1. After link-up, ALIGN, then exactly 8 ch1 words.
- Drop tx_ready mid-stream with 5 words queued -> next cycle IDLE_WORD. On re-assertion, 4 sync words, then the remaining words with none lost or duplicated.
- Assert rst low mid-RUN, asynchronously between edges -> outputs return to their reset values immediately and FIFOs are empty.
